// File: rtl/inst_queue.sv
// inst_queue: instruction prefetch FIFO between fetch and decode.
// Control-flow opcodes are pre-decoded on enqueue; a flush discards every entry.
`default_nettype none

module inst_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_inst,
  input  logic [31:0]   in_pc,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_inst,
  output logic [31:0]   out_pc,
  output logic          out_is_branch,
  output logic          out_is_branchn,
  output logic          out_is_jump,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  localparam logic [5:0]  OP_BEQ   = 6'b000100;
  localparam logic [5:0]  OP_BNE   = 6'b000101;
  localparam logic [5:0]  OP_J     = 6'b000010;
  localparam logic [5:0]  OP_JAL   = 6'b000011;

  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic [2:0]    flag_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;

  logic       enq;
  logic       deq;
  logic [5:0] opcode;
  logic [2:0] in_flags;
  logic [2:0] head_flags;

  assign in_ready  = (cnt != FULL_CNT);
  assign out_valid = (cnt != '0);
  assign count     = cnt;

  assign enq = in_valid && in_ready && !flush;
  assign deq = out_valid && out_ready && !flush;

  // Flags are stored with the entry: {jump, branchn, branch}.
  assign opcode   = in_inst[31:26];
  assign in_flags = {(opcode == OP_J) || (opcode == OP_JAL),
                     (opcode == OP_BNE),
                     (opcode == OP_BEQ)};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem[i] <= '0;
        pc_mem[i]   <= '0;
        flag_mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq) begin
        inst_mem[wr_ptr] <= in_inst;
        pc_mem[wr_ptr]   <= in_pc;
        flag_mem[wr_ptr] <= in_flags;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (enq && !deq) begin
        cnt <= cnt + (AW+1)'(1);
      end else if (deq && !enq) begin
        cnt <= cnt - (AW+1)'(1);
      end
    end
  end

  // Stale storage is masked so decode never sees a non-zero word on an empty queue.
  always_comb begin
    out_inst   = '0;
    out_pc     = '0;
    head_flags = '0;
    if (out_valid) begin
      out_inst   = inst_mem[rd_ptr];
      out_pc     = pc_mem[rd_ptr];
      head_flags = flag_mem[rd_ptr];
    end
  end

  assign out_is_branch  = head_flags[0];
  assign out_is_branchn = head_flags[1];
  assign out_is_jump    = head_flags[2];

endmodule

`default_nettype wire

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue.
`default_nettype none

module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_is_branch;
  logic        out_is_branchn;
  logic        out_is_jump;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  inst_queue #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_is_branch(out_is_branch), .out_is_branchn(out_is_branchn), .out_is_jump(out_is_jump),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag, input logic [2:0] exp);
    check(tag, {29'd0, out_is_jump, out_is_branchn, out_is_branch}, {29'd0, exp});
  endtask

  logic [31:0] flag_words [4];
  logic [2:0]  flag_exp   [4];

  initial begin
    flag_words[0] = 32'h10220003; flag_exp[0] = 3'b001;
    flag_words[1] = 32'h14220003; flag_exp[1] = 3'b010;
    flag_words[2] = 32'h08000010; flag_exp[2] = 3'b100;
    flag_words[3] = 32'h0C000010; flag_exp[3] = 3'b100;

    rst = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_inst", out_inst, 32'd0);
    @(negedge clk) rst = 1'b1;
    #1;
    check("rst_ready", {31'd0, in_ready}, 32'd1);

    // Single enqueue, no bypass
    in_valid = 1'b1; in_inst = 32'h20080005; in_pc = 32'h0;
    check("nobypass", {31'd0, out_valid}, 32'd0);
    tick();
    in_valid = 1'b0;
    check("one_valid", {31'd0, out_valid}, 32'd1);
    check("one_inst", out_inst, 32'h20080005);
    check("one_pc", out_pc, 32'h0);
    check_flags("one_flags", 3'b000);
    check("one_count", {29'd0, count}, 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("one_drain", {29'd0, count}, 32'd0);

    // Fill to full, fifth word held off
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'(4 * i); in_inst = 32'h00000100 + 32'(i);
      tick();
    end
    check("full_count", {29'd0, count}, 32'd4);
    check("full_ready", {31'd0, in_ready}, 32'd0);
    in_pc = 32'h10; in_inst = 32'hDEADBEEF;
    tick();
    check("full_hold", {29'd0, count}, 32'd4);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", out_pc, 32'(4 * i));
      check("drain_inst", out_inst, 32'h00000100 + 32'(i));
      tick();
    end
    out_ready = 1'b0;
    check("drain_empty", {31'd0, out_valid}, 32'd0);

    // Steady stream of 10 words
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; out_ready = 1'b1;
      in_pc = 32'h200 + 32'(4 * i); in_inst = 32'h00001000 + 32'(i);
      if (i > 0) begin
        check("stream_count", {29'd0, count}, 32'd1);
        check("stream_pc", out_pc, 32'h200 + 32'(4 * (i - 1)));
      end
      tick();
    end
    in_valid = 1'b0;
    check("stream_last", out_pc, 32'h200 + 32'(4 * 9));
    tick();
    out_ready = 1'b0;
    check("stream_empty", {29'd0, count}, 32'd0);

    // Pre-decode flags
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_inst = flag_words[i]; in_pc = 32'h300 + 32'(4 * i);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_flags("flags", flag_exp[i]);
      tick();
    end
    out_ready = 1'b0;

    // Flush with concurrent enqueue and dequeue
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_inst = 32'h00002000 + 32'(i); in_pc = 32'h400 + 32'(4 * i);
      tick();
    end
    check("preflush_count", {29'd0, count}, 32'd3);
    in_inst = 32'hBADBAD00; in_pc = 32'h500; out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    check("flush_count", {29'd0, count}, 32'd0);
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_inst", out_inst, 32'd0);
    in_inst = 32'h10220003; in_pc = 32'h600;
    tick();
    in_valid = 1'b0;
    check("postflush_pc", out_pc, 32'h600);
    check_flags("postflush_flags", 3'b001);
    check("postflush_count", {29'd0, count}, 32'd1);

    // Asynchronous reset mid-burst
    in_valid = 1'b1; in_inst = 32'h00003000; in_pc = 32'h700;
    tick();
    check("burst_count", {29'd0, count}, 32'd2);
    #2 rst = 1'b0;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_count", {29'd0, count}, 32'd0);
    check("arst_pc", out_pc, 32'd0);
    in_valid = 1'b0;
    @(negedge clk) rst = 1'b1;
    tick();
    check("arst_ready", {31'd0, in_ready}, 32'd1);
    check("arst_stay", {29'd0, count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Small instruction prefetch buffer sitting directly downstream of the instruction fetch unit and upstream of decode/control.
- Accepts fetched words with their PC over a valid/ready handshake and holds them in a circular FIFO.
- Pre-decodes control-flow opcodes at enqueue and presents the oldest entry to decode.
- Flushes on control-flow redirect so wrong-path words never reach decode.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- AW, 2, pointer width; must equal log2(DEPTH).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  fetch side presents a word this cycle
- in_ready  out  1  queue can accept a word this cycle
- in_inst  in  32  fetched instruction word
- in_pc  in  32  byte address of in_inst
- flush  in  1  synchronous discard of all entries (redirect)
- out_valid  out  1  head entry is valid
- out_ready  in  1  decode consumes head this cycle
- out_inst  out  32  head instruction word
- out_pc  out  32  head PC
- out_is_branch  out  1  head opcode inst[31:26]==6'b000100 (beq)
- out_is_branchn  out  1  head opcode ==6'b000101 (bne)
- out_is_jump  out  1  head opcode ==6'b000010 or 6'b000011
- count  out  AW+1  number of occupied entries, 0..DEPTH

Behaviour:
- Reset (rst=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, all storage cleared, out_valid=0, all out_* zero, in_ready=1 after release.
- Enqueue fires when in_valid && in_ready && !flush: write {inst, pc, three pre-decode flags} at wr_ptr; wr_ptr += 1 mod DEPTH.
- Dequeue fires when out_valid && out_ready && !flush: rd_ptr += 1 mod DEPTH.
- count updates as count + enq - deq; simultaneous enq and deq leave count unchanged.
- in_ready = (count != DEPTH). Combinational from registered count only; no dependence on out_ready, so there is no same-cycle pass-through when full.
- out_valid = (count != 0). There is no bypass: a word enqueued in cycle N is visible at the head in cycle N+1 at the earliest (1-cycle latency).
- out_inst/out_pc/flags are read from storage at rd_ptr and are forced to 0 whenever out_valid=0.
- Pre-decode flags are computed from in_inst at enqueue and stored with the entry; they are never recomputed from the head word.
- Flush (synchronous, highest priority): next cycle wr_ptr=rd_ptr=0, count=0, out_valid=0. Any enqueue or dequeue in the flush cycle is discarded. Storage contents need not be cleared.
- Pointer wrap: both pointers wrap from DEPTH-1 to 0; full versus empty is distinguished by count, not by pointer equality.
- Empty with out_ready=1: no state change. Full with in_valid=1: word not accepted; the upstream stage must hold it.
- Reset asserted mid-operation: all state returns to reset values immediately, independent of clk.

Test Plan:
- Reset, then enqueue 0x20080005 at pc 0x0, out_ready=0 -> next cycle out_valid=1, out_inst=0x20080005, out_pc=0, all flags 0, count=1.
- Enqueue 4 words (pc 0,4,8,C) with out_ready=0 -> count=4, in_ready=0. Fifth word (pc 0x10) is held and not written. Drain with out_ready=1 -> pcs emerge 0,4,8,C in order.
- Steady stream with in_valid=out_ready=1 every cycle for 10 words -> count stays 1 after fill, no word lost or duplicated, pointers wrap twice.
- Enqueue 0x10220003 (beq), 0x14220003 (bne), 0x08000010 (j), 0x0C000010 (jal) -> head flags respectively branch=1; branchn=1; jump=1; jump=1; the others 0 in each case.
- With 3 entries queued, assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, out_inst=0; the flush-cycle word is absent. A following enqueue appears as the head one cycle later.
- Drop rst mid-burst between clock edges -> out_valid and count go to 0 immediately, in_ready=1 after release.
